// File: rtl/uart_tx.sv
// uart_tx -- byte-wide UART serial transmitter.
//
// Takes a byte through a start/busy handshake and shifts it out on tx_out as
// start bit, 8 data bits (MSB first), an optional parity bit and 1 or 2 stop
// bits. Each bit is held for CLKS_PER_BIT clocks. tx_out idles high and is
// driven from a register.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high; aborts any frame in flight
//   tx_start  in   send request, sampled only while idle (never queued)
//   tx_data   in   [7:0] byte to send, captured on the accepting edge
//   tx_busy   out  high from the accepting edge until the frame completes
//   tx_done   out  one-cycle pulse as the frame completes
//   tx_out    out  serial line
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_out
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             bit_end;
  logic             stop_end;
  logic             tx_out_nxt;
  logic             tx_busy_nxt;
  logic             tx_done_nxt;

  function automatic logic parity_of(input logic [7:0] b);
    return (^b) ^ PARITY_ODD;
  endfunction

  assign bit_end  = (baud_cnt == CNT_MAX);
  // bit_idx is free while in STOP, so it doubles as the stop-bit counter
  assign stop_end = bit_end && (bit_idx == STOP_LAST);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_out  <= tx_out_nxt;
      tx_busy <= tx_busy_nxt;
      tx_done <= tx_done_nxt;
    end
  end

  // Baud counter, bit index, shift register and latched parity
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else if (state == S_IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      if (tx_start) begin
        shreg   <= tx_data;
        par_bit <= parity_of(tx_data);
      end
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if (bit_end) begin
        if (state == S_DATA) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_idx <= bit_idx + 3'd1;
        end else if (state == S_STOP) begin
          bit_idx <= stop_end ? 3'd0 : bit_idx + 3'd1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (tx_start) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && (bit_idx == 3'd7)) state_nxt = PARITY_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (stop_end) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: value each output takes after the coming edge
  always_comb begin
    tx_out_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_out_nxt = 1'b0;
      // On a DATA bit boundary the shift has not landed yet, so look one bit ahead
      S_DATA:   tx_out_nxt = ((state == S_DATA) && bit_end) ? shreg[6] : shreg[7];
      S_PARITY: tx_out_nxt = par_bit;
      default:  tx_out_nxt = 1'b1;
    endcase
    tx_busy_nxt = (state_nxt != S_IDLE);
    tx_done_nxt = (state == S_STOP) && (state_nxt == S_IDLE);
  end

endmodule
